// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the 32-bit multicycle MIPS core.
// Sequences fetch/decode/execute/memory/write-back over a shared datapath and
// drives every datapath select and strobe, plus the gated PC enable.
// Optional feature macro: ARITH_OVF_TRAP_EN (signed-overflow trap on add/sub/addi).
module multicycle_control #(
   parameter int N = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       ALUZero,
   input  logic       ALUOverflow,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemToReg,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic       Branch,
   output logic       BranchNe,
   output logic [1:0] PCSource,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUControl,
   output logic       illegal,
   output logic       ovf_trap,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                          S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                          S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                          S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW  = 6'b101011,
                          OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                          OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                          FN_OR  = 6'b100101, FN_SLT = 6'b101010, FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                          ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;

   // Width parameter is informational; tie it off so it stays referenced.
   logic [N-1:0] unused_width_s;
   assign unused_width_s = {N{1'b0}};

   logic [3:0] state_q, state_d;
   // Instruction class remembered from DECODE, since opcode is only read there.
   logic       sw_q, sw_d;
   logic       bne_q, bne_d;
   logic       r_legal_s, legal_s, trap_s, pc_write_s;
   logic       mem_read_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;

   // Classify funct for R-type legality.
   always_comb begin
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: r_legal_s = 1'b1;
         default:                                       r_legal_s = 1'b0;
      endcase
   end

   // Classify opcode for overall instruction legality.
   always_comb begin
      case (opcode)
         OP_RTYPE:                                     legal_s = r_legal_s;
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J:  legal_s = 1'b1;
         default:                                      legal_s = 1'b0;
      endcase
   end

   // Next-state logic; unreachable encodings fall back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      sw_d    = sw_q;
      bne_d   = bne_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            sw_d  = (opcode == OP_SW);
            bne_d = (opcode == OP_BNE);
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE:       state_d = r_legal_s ? S_EXEC : S_FETCH;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_J:           state_d = S_JUMP;
               default:        state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // State and instruction-class registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         sw_q    <= 1'b0;
         bne_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sw_q    <= sw_d;
         bne_q   <= bne_d;
      end
   end

`ifdef ARITH_OVF_TRAP_EN
   logic ovf_q, ovf_d;
   // Set when the executing op is one that may trap (add/sub/addi).
   logic arith_q, arith_d;

   // Capture overflow at the end of EXEC/ADDIEX, clear it in FETCH.
   always_comb begin
      ovf_d   = ovf_q;
      arith_d = arith_q;
      case (state_q)
         S_FETCH:  ovf_d = 1'b0;
         S_EXEC: begin
            ovf_d   = ALUOverflow;
            arith_d = (funct == FN_ADD) || (funct == FN_SUB);
         end
         S_ADDIEX: begin
            ovf_d   = ALUOverflow;
            arith_d = 1'b1;
         end
         default:  ovf_d = ovf_q;
      endcase
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q   <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         ovf_q   <= ovf_d;
         arith_q <= arith_d;
      end
   end

   assign trap_s = ovf_q && arith_q && ((state_q == S_ALUWB) || (state_q == S_ADDIWB));
`else
   // Overflow is ignored in this build.
   logic unused_ovf_s;
   assign unused_ovf_s = ALUOverflow;
   assign trap_s       = 1'b0;
`endif

   // Moore output decode from the registered state.
   always_comb begin
      pc_write_s  = 1'b0;
      IorD        = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      MemToReg    = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      Branch      = 1'b0;
      BranchNe    = 1'b0;
      PCSource    = 2'd0;
      ALUSrcB     = 2'd0;
      ALUControl  = ALU_ADD;
      illegal_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_s = 1'b1;
            ir_write_s = 1'b1;
            ALUSrcB    = 2'd1;
            pc_write_s = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB   = 2'd3;
            illegal_s = !legal_s;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
         end
         S_MEMRD: begin
            IorD       = 1'b1;
            mem_read_s = 1'b1;
         end
         S_MEMWB: begin
            MemToReg    = 1'b1;
            reg_write_s = 1'b1;
         end
         S_MEMWR: begin
            IorD        = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            case (funct)
               FN_SUB:  ALUControl = ALU_SUB;
               FN_AND:  ALUControl = ALU_AND;
               FN_OR:   ALUControl = ALU_OR;
               FN_SLT:  ALUControl = ALU_SLT;
               FN_NOR:  ALUControl = ALU_NOR;
               default: ALUControl = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            RegDst      = 1'b1;
            reg_write_s = !trap_s;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSource   = 2'd1;
            Branch     = !bne_q;
            BranchNe   = bne_q;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
         end
         S_ADDIWB: reg_write_s = !trap_s;
         S_JUMP: begin
            PCSource   = 2'd2;
            pc_write_s = 1'b1;
         end
         default: pc_write_s = 1'b0;
      endcase
   end

   // Strobes are forced low while reset is held so an aborted instruction writes nothing.
   assign PCEn     = rst & (pc_write_s | (Branch & ALUZero) | (BranchNe & ~ALUZero));
   assign MemRead  = rst & mem_read_s;
   assign MemWrite = rst & mem_write_s;
   assign IRWrite  = rst & ir_write_s;
   assign RegWrite = rst & reg_write_s;
   assign illegal  = rst & illegal_s;
   assign ovf_trap = rst & trap_s;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Build with +define+ARITH_OVF_TRAP_EN to exercise the overflow-trap variant.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       ALUZero, ALUOverflow;
   logic       PCEn, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst;
   logic       ALUSrcA, Branch, BranchNe, illegal, ovf_trap;
   logic [1:0] PCSource, ALUSrcB;
   logic [3:0] ALUControl, state;

   int n_vec = 0;
   int n_err = 0;

   multicycle_control #(.N(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .ALUZero(ALUZero), .ALUOverflow(ALUOverflow),
      .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemToReg(MemToReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .Branch(Branch), .BranchNe(BranchNe),
      .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .illegal(illegal), .ovf_trap(ovf_trap), .state(state)
   );

   always #5 clk = ~clk;

`ifdef ARITH_OVF_TRAP_EN
   localparam logic TRAP_ON = 1'b1;
`else
   localparam logic TRAP_ON = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled at the falling edge.
   task automatic nc;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; opcode = 6'b000000; funct = 6'b000000;
      ALUZero = 1'b0; ALUOverflow = 1'b0;

      // Reset held 3 cycles
      repeat (3) @(posedge clk);
      nc;
      check("rst_state", state, 4'd0);
      check("rst_pcen", PCEn, 1'b0);
      check("rst_memrd", MemRead, 1'b0);
      check("rst_irw", IRWrite, 1'b0);
      check("rst_regw", RegWrite, 1'b0);
      check("rst_memwr", MemWrite, 1'b0);
      rst = 1'b1; #1;
      check("fetch_memrd", MemRead, 1'b1);
      check("fetch_irw", IRWrite, 1'b1);
      check("fetch_pcen", PCEn, 1'b1);
      check("fetch_srcb", ALUSrcB, 2'd1);

      // lw: 0,1,2,3,4
      opcode = 6'b100011;
      nc; check("lw_s1", state, 4'd1); check("lw_dec_srcb", ALUSrcB, 2'd3);
      check("lw_dec_pcen", PCEn, 1'b0);
      nc; check("lw_s2", state, 4'd2); check("lw_srca", ALUSrcA, 1'b1); check("lw_srcb", ALUSrcB, 2'd2);
      nc; check("lw_s3", state, 4'd3); check("lw_iord3", IorD, 1'b1); check("lw_memrd3", MemRead, 1'b1);
      check("lw_regw3", RegWrite, 1'b0);
      nc; check("lw_s4", state, 4'd4); check("lw_regw4", RegWrite, 1'b1); check("lw_m2r4", MemToReg, 1'b1);
      check("lw_regdst4", RegDst, 1'b0);
      nc; check("lw_done", state, 4'd0);

      // sw: 0,1,2,5
      opcode = 6'b101011;
      nc; check("sw_s1", state, 4'd1); check("sw_memwr1", MemWrite, 1'b0);
      nc; check("sw_s2", state, 4'd2); check("sw_memwr2", MemWrite, 1'b0);
      nc; check("sw_s5", state, 4'd5); check("sw_memwr5", MemWrite, 1'b1); check("sw_iord5", IorD, 1'b1);
      nc; check("sw_done", state, 4'd0); check("sw_memwr0", MemWrite, 1'b0);

      // R-type sub and slt
      opcode = 6'b000000; funct = 6'b100010;
      nc; check("sub_s1", state, 4'd1);
      nc; check("sub_s6", state, 4'd6); check("sub_aluc", ALUControl, 4'b0110); check("sub_srcb", ALUSrcB, 2'd0);
      nc; check("sub_s7", state, 4'd7); check("sub_regdst", RegDst, 1'b1); check("sub_regw", RegWrite, 1'b1);
      nc; check("sub_done", state, 4'd0);
      funct = 6'b101010;
      nc; nc; check("slt_aluc", ALUControl, 4'b0111);
      nc; check("slt_regw", RegWrite, 1'b1);
      nc; check("slt_done", state, 4'd0);

      // beq taken, with combinational ALUZero dependency
      opcode = 6'b000100; ALUZero = 1'b1;
      nc; nc; check("beq_s8", state, 4'd8); check("beq_pcen", PCEn, 1'b1); check("beq_pcsrc", PCSource, 2'd1);
      check("beq_aluc", ALUControl, 4'b0110); check("beq_br", Branch, 1'b1);
      ALUZero = 1'b0; #1; check("beq_comb_pcen", PCEn, 1'b0);
      nc; check("beq_done", state, 4'd0);
      // beq not taken
      nc; nc; check("beqnt_pcen", PCEn, 1'b0);
      nc; check("beqnt_done", state, 4'd0);
      // bne taken / not taken
      opcode = 6'b000101; ALUZero = 1'b0;
      nc; nc; check("bne_s8", state, 4'd8); check("bne_pcen", PCEn, 1'b1); check("bne_brne", BranchNe, 1'b1);
      check("bne_br", Branch, 1'b0);
      ALUZero = 1'b1; #1; check("bne_z_pcen", PCEn, 1'b0);
      nc; check("bne_done", state, 4'd0); ALUZero = 1'b0;

      // j
      opcode = 6'b000010;
      nc; nc; check("j_s11", state, 4'd11); check("j_pcsrc", PCSource, 2'd2); check("j_pcen", PCEn, 1'b1);
      nc; check("j_done", state, 4'd0);

      // illegal opcode and illegal funct
      opcode = 6'b111111;
      nc; check("ill_s1", state, 4'd1); check("ill_flag", illegal, 1'b1);
      check("ill_regw", RegWrite, 1'b0); check("ill_memwr", MemWrite, 1'b0);
      nc; check("ill_done", state, 4'd0); check("ill_clr", illegal, 1'b0);
      opcode = 6'b000000; funct = 6'b000000;
      nc; check("illf_flag", illegal, 1'b1);
      nc; check("illf_done", state, 4'd0);

      // addi with overflow in ADDIEX
      opcode = 6'b001000;
      nc; nc; check("addi_s9", state, 4'd9); ALUOverflow = 1'b1;
      nc; ALUOverflow = 1'b0; check("addi_s10", state, 4'd10);
      check("addi_ovf_regw", RegWrite, !TRAP_ON); check("addi_ovf_trap", ovf_trap, TRAP_ON);
      nc; check("addi_done", state, 4'd0); check("addi_trap_clr", ovf_trap, 1'b0);
      // addi clean: stale overflow must be gone
      nc; nc; nc; check("addi_ok_regw", RegWrite, 1'b1); check("addi_ok_trap", ovf_trap, 1'b0);
      nc;

      // R add with overflow traps; R and with overflow does not
      opcode = 6'b000000; funct = 6'b100000;
      nc; nc; ALUOverflow = 1'b1;
      nc; ALUOverflow = 1'b0;
      check("add_ovf_regw", RegWrite, !TRAP_ON); check("add_ovf_trap", ovf_trap, TRAP_ON);
      nc; funct = 6'b100100;
      nc; nc; check("and_aluc", ALUControl, 4'b0000); ALUOverflow = 1'b1;
      nc; ALUOverflow = 1'b0; check("and_ovf_regw", RegWrite, 1'b1); check("and_ovf_trap", ovf_trap, 1'b0);
      nc; check("and_done", state, 4'd0);

      // Reset mid-lw in MEMWB: no write in reset cycle, back to FETCH
      opcode = 6'b100011;
      nc; nc; nc; nc; check("abort_s4", state, 4'd4);
      rst = 1'b0; #1; check("abort_regw", RegWrite, 1'b0); check("abort_pcen", PCEn, 1'b0);
      nc; check("abort_state", state, 4'd0); check("abort_memrd", MemRead, 1'b0);
      rst = 1'b1; #1; check("abort_fetch", MemRead, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
